// File: rtl/hazard_scoreboard_pkg.sv
// Shared constants and slot types for the P6 producer-side hazard unit.
// Tnew/Tuse are 2-bit cycle counts; MD op codes classify HI/LO instructions.
package hazard_scoreboard_pkg;

    localparam logic [1:0] TUSE_NONE = 2'd3;
    localparam logic [1:0] TNEW_ALU  = 2'd1;
    localparam logic [1:0] TNEW_LOAD = 2'd2;
    localparam logic [1:0] TNEW_LINK = 2'd0;

    typedef enum logic [1:0] {
        MD_NONE = 2'b00,
        MD_MULT = 2'b01,
        MD_DIV  = 2'b10,
        MD_HILO = 2'b11
    } md_op_e;

    typedef struct packed {
        logic [4:0] a3;
        logic [1:0] tnew;
        md_op_e     md_op;
    } e_slot_t;

    typedef struct packed {
        logic [4:0] a3;
        logic [1:0] tnew;
    } m_slot_t;

    function automatic logic [1:0] sat_dec(input logic [1:0] x);
        return (x == 2'd0) ? 2'd0 : x - 2'd1;
    endfunction

endpackage

// File: rtl/hazard_scoreboard_mdu_busy_counter.sv
// Multiply/divide busy countdown: a start loads the count, otherwise it
// counts down to zero and holds. Busy covers the start cycle itself.
module mdu_busy_counter #(
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] load_val,
    output logic             busy
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (start) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign busy = (count != '0) || start;

endmodule

// File: rtl/hazard_scoreboard.sv
// Producer-side hazard unit: tracks A3/Tnew through E, M, W, raises the
// D-stage stall and publishes per-stage destinations and ready flags.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10,
    parameter int unsigned CNT_W       = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] D_A1,
    input  logic [4:0] D_A2,
    input  logic [1:0] D_Tuse_rs,
    input  logic [1:0] D_Tuse_rt,
    input  logic [4:0] D_A3,
    input  logic [1:0] D_Tnew,
    input  logic       D_md_use,
    input  logic [1:0] D_md_op,
    output logic       stall,
    output logic [4:0] E_A3,
    output logic [4:0] M_A3,
    output logic [4:0] W_A3,
    output logic       E_ready,
    output logic       M_ready,
    output logic       mdu_busy
);

    e_slot_t    e_slot;
    m_slot_t    m_slot;
    logic [4:0] w_a3;

    logic             mdu_start;
    logic [CNT_W-1:0] mdu_load;
    logic             stall_rs;
    logic             stall_rt;
    logic             stall_md;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            e_slot <= '0;
            m_slot <= '0;
            w_a3   <= '0;
        end else begin
            w_a3        <= m_slot.a3;
            m_slot.a3   <= e_slot.a3;
            m_slot.tnew <= sat_dec(e_slot.tnew);
            if (stall) begin
                e_slot.a3    <= '0;
                e_slot.tnew  <= TNEW_LINK;
                e_slot.md_op <= MD_NONE;
            end else begin
                e_slot.a3    <= D_A3;
                e_slot.tnew  <= D_Tnew;
                e_slot.md_op <= md_op_e'(D_md_op);
            end
        end
    end

    assign mdu_start = (e_slot.md_op == MD_MULT) || (e_slot.md_op == MD_DIV);
    assign mdu_load  = (e_slot.md_op == MD_MULT) ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);

    mdu_busy_counter #(
        .CNT_W(CNT_W)
    ) u_mdu_busy_counter (
        .clk      (clk),
        .reset    (reset),
        .start    (mdu_start),
        .load_val (mdu_load),
        .busy     (mdu_busy)
    );

    // $0 is excluded up front, so a zero destination in E/M can never match.
    always_comb begin
        stall_rs = 1'b0;
        stall_rt = 1'b0;
        if (D_A1 != 5'd0) begin
            stall_rs = ((D_A1 == e_slot.a3) && (e_slot.tnew > D_Tuse_rs)) ||
                       ((D_A1 == m_slot.a3) && (m_slot.tnew > D_Tuse_rs));
        end
        if (D_A2 != 5'd0) begin
            stall_rt = ((D_A2 == e_slot.a3) && (e_slot.tnew > D_Tuse_rt)) ||
                       ((D_A2 == m_slot.a3) && (m_slot.tnew > D_Tuse_rt));
        end
    end

    assign stall_md = D_md_use && mdu_busy;
    assign stall    = stall_rs | stall_rt | stall_md;

    assign E_A3    = e_slot.a3;
    assign M_A3    = m_slot.a3;
    assign W_A3    = w_a3;
    assign E_ready = (e_slot.tnew == 2'd0);
    assign M_ready = (m_slot.tnew == 2'd0);

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed vector table, MDU/reset sequences,
// then random traffic against a cycle-time reference model.
module tb_hazard_scoreboard;

    logic       clk;
    logic       reset;
    logic [4:0] d_a1, d_a2, d_a3;
    logic [1:0] d_tuse_rs, d_tuse_rt, d_tnew, d_md_op;
    logic       d_md_use;
    logic       stall, e_ready, m_ready, mdu_busy;
    logic [4:0] e_a3, m_a3, w_a3;

    int vectors = 0;
    int miscompares = 0;

    hazard_scoreboard #(
        .MULT_CYCLES(5),
        .DIV_CYCLES (10),
        .CNT_W      (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .D_A1      (d_a1),
        .D_A2      (d_a2),
        .D_Tuse_rs (d_tuse_rs),
        .D_Tuse_rt (d_tuse_rt),
        .D_A3      (d_a3),
        .D_Tnew    (d_tnew),
        .D_md_use  (d_md_use),
        .D_md_op   (d_md_op),
        .stall     (stall),
        .E_A3      (e_a3),
        .M_A3      (m_a3),
        .W_A3      (w_a3),
        .E_ready   (e_ready),
        .M_ready   (m_ready),
        .mdu_busy  (mdu_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] a1, a2;
        logic [1:0] tr, tt;
        logic [4:0] a3;
        logic [1:0] tn;
        logic       mu;
        logic [1:0] mo;
        logic       s;
        logic [4:0] ea, ma, wa;
        logic       er, mr, mb;
    } vec_t;

    function automatic vec_t mk(input int a1, input int a2, input int tr, input int tt,
                                input int a3, input int tn, input int mu, input int mo,
                                input int s, input int ea, input int ma, input int wa,
                                input int er, input int mr, input int mb);
        vec_t v;
        v.a1 = 5'(a1); v.a2 = 5'(a2); v.tr = 2'(tr); v.tt = 2'(tt);
        v.a3 = 5'(a3); v.tn = 2'(tn); v.mu = 1'(mu); v.mo = 2'(mo);
        v.s = 1'(s); v.ea = 5'(ea); v.ma = 5'(ma); v.wa = 5'(wa);
        v.er = 1'(er); v.mr = 1'(mr); v.mb = 1'(mb);
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input int s, input int ea, input int ma,
                           input int wa, input int er, input int mr, input int mb);
        vectors++;
        chk({tag, ".stall"}, int'(stall), s);
        chk({tag, ".E_A3"}, int'(e_a3), ea);
        chk({tag, ".M_A3"}, int'(m_a3), ma);
        chk({tag, ".W_A3"}, int'(w_a3), wa);
        chk({tag, ".E_ready"}, int'(e_ready), er);
        chk({tag, ".M_ready"}, int'(m_ready), mr);
        chk({tag, ".mdu_busy"}, int'(mdu_busy), mb);
    endtask

    task automatic drive(input int a1, input int a2, input int tr, input int tt,
                         input int a3, input int tn, input int mu, input int mo);
        if (tn == 3) begin
            miscompares++;
            $display("FAIL illegal_tnew: got %0d expected 0..2", tn);
        end
        d_a1 = 5'(a1); d_a2 = 5'(a2); d_tuse_rs = 2'(tr); d_tuse_rt = 2'(tt);
        d_a3 = 5'(a3); d_tnew = 2'(tn); d_md_use = 1'(mu); d_md_op = 2'(mo);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(0, 0, 3, 3, 0, 0, 0, 0);
        reset = 1'b0;
        #3;
        next_cycle();
        chk_all("reset_held", 0, 0, 0, 0, 1, 1, 0);
        reset = 1'b1;
        #1;
        chk_all("reset_released", 0, 0, 0, 0, 1, 1, 0);
    endtask

    // Reference model: absolute cycle at which each stage's result exists,
    // and the last MDU start time; busy spans [start, start + N].
    int now, e_dst, e_rdy, e_md, m_dst, m_rdy, w_dst, last_start, last_n;

    task automatic model_init();
        now = 0; e_dst = 0; e_rdy = 0; e_md = 0;
        m_dst = 0; m_rdy = 0; w_dst = 0; last_start = 0; last_n = 0;
    endtask

    function automatic int remaining(input int rdy);
        return (rdy > now) ? rdy - now : 0;
    endfunction

    function automatic bit model_busy();
        return (last_n != 0) && (now <= last_start + last_n);
    endfunction

    function automatic bit hazard(input int a, input int tu);
        if (a == 0) return 1'b0;
        return ((a == e_dst) && (remaining(e_rdy) > tu)) ||
               ((a == m_dst) && (remaining(m_rdy) > tu));
    endfunction

    task automatic model_advance(input bit stl, input int a3, input int tn, input int mo);
        w_dst = m_dst;
        m_dst = e_dst;
        m_rdy = e_rdy;
        now++;
        if (stl) begin
            e_dst = 0; e_rdy = now; e_md = 0;
        end else begin
            e_dst = a3; e_rdy = now + tn; e_md = mo;
        end
        if (e_md == 1) begin
            last_start = now; last_n = 5;
        end else if (e_md == 2) begin
            last_start = now; last_n = 10;
        end
    endtask

    vec_t tbl[$];

    initial begin
        int n;
        reset = 1'b0;
        drive(0, 0, 3, 3, 0, 0, 0, 0);

        // Directed table: lw/use, ALU/branch, and $0 destination cases.
        tbl.push_back(mk(29, 0, 1, 3,  8, 2, 0, 0,  0,  0,  0,  0, 1, 1, 0));
        tbl.push_back(mk( 8, 9, 1, 1, 10, 1, 0, 0,  1,  8,  0,  0, 0, 1, 0));
        tbl.push_back(mk( 8, 9, 1, 1, 10, 1, 0, 0,  0,  0,  8,  0, 1, 0, 0));
        tbl.push_back(mk(10, 0, 0, 0,  0, 0, 0, 0,  1, 10,  0,  8, 0, 1, 0));
        tbl.push_back(mk(10, 0, 0, 0,  0, 0, 0, 0,  0,  0, 10,  0, 1, 1, 0));
        tbl.push_back(mk( 0, 0, 3, 3,  0, 2, 0, 0,  0,  0,  0, 10, 1, 1, 0));
        tbl.push_back(mk( 0, 0, 0, 0, 12, 1, 0, 0,  0,  0,  0,  0, 0, 1, 0));
        tbl.push_back(mk( 0, 0, 0, 0,  0, 0, 0, 0,  0, 12,  0,  0, 0, 0, 0));

        do_reset();
        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].a1, tbl[i].a2, tbl[i].tr, tbl[i].tt,
                  tbl[i].a3, tbl[i].tn, tbl[i].mu, tbl[i].mo);
            #2;
            chk_all($sformatf("tbl%0d", i), tbl[i].s, tbl[i].ea, tbl[i].ma,
                    tbl[i].wa, tbl[i].er, tbl[i].mr, tbl[i].mb);
            next_cycle();
        end

        // div then mflo: stall covers the start cycle plus DIV_CYCLES of count.
        for (int k = 0; k < 2; k++) begin
            int op   = (k == 0) ? 2 : 1;
            int need = (k == 0) ? 11 : 6;
            do_reset();
            drive(4, 5, 1, 1, 0, 1, 1, op);
            #2;
            vectors++;
            chk($sformatf("md%0d_start_stall", k), int'(stall), 0);
            next_cycle();
            drive(0, 0, 3, 3, 8, 1, 1, 0);
            #2;
            n = 0;
            while (stall && n < 40) begin
                vectors++;
                chk($sformatf("md%0d_busy_during_stall", k), int'(mdu_busy), 1);
                n++;
                next_cycle();
                #1;
            end
            vectors++;
            chk($sformatf("md%0d_stall_len", k), n, need);
            chk($sformatf("md%0d_busy_after", k), int'(mdu_busy), 0);
            next_cycle();
            drive(0, 0, 3, 3, 0, 0, 0, 0);
            #1;
            vectors++;
            chk($sformatf("md%0d_mflo_in_E", k), int'(e_a3), 8);
        end

        // Async reset mid-div at count 6 drops busy and stall immediately.
        do_reset();
        drive(4, 5, 1, 1, 0, 1, 1, 2);
        next_cycle();
        drive(0, 0, 3, 3, 8, 1, 1, 0);
        repeat (5) next_cycle();
        #2;
        vectors++;
        chk("midreset_busy_before", int'(mdu_busy), 1);
        chk("midreset_stall_before", int'(stall), 1);
        reset = 1'b0;
        #1;
        chk_all("midreset_async", 0, 0, 0, 0, 1, 1, 0);
        next_cycle();
        reset = 1'b1;
        #1;
        chk_all("midreset_release", 0, 0, 0, 0, 1, 1, 0);
        next_cycle();
        #1;
        chk_all("midreset_mflo_in_E", 0, 8, 0, 0, 0, 1, 0);

        // Random traffic against the reference model.
        do_reset();
        model_init();
        for (int i = 0; i < 2000; i++) begin
            int a1, a2, tr, tt, a3, tn, mu, mo;
            bit exp_s, exp_b;
            a1 = int'($urandom_range(0, 3));
            a2 = int'($urandom_range(0, 3));
            tr = int'($urandom_range(0, 3));
            tt = int'($urandom_range(0, 3));
            a3 = int'($urandom_range(0, 3));
            tn = int'($urandom_range(0, 2));
            mu = ($urandom_range(0, 3) == 0) ? 1 : 0;
            mo = (mu != 0) ? int'($urandom_range(0, 3)) : 0;
            drive(a1, a2, tr, tt, a3, tn, mu, mo);
            #2;
            exp_b = model_busy();
            exp_s = hazard(a1, tr) || hazard(a2, tt) || ((mu != 0) && exp_b);
            chk_all($sformatf("rand%0d", i), int'(exp_s), e_dst, m_dst, w_dst,
                    (remaining(e_rdy) == 0) ? 1 : 0, (remaining(m_rdy) == 0) ? 1 : 0,
                    int'(exp_b));
            next_cycle();
            model_advance(exp_s, a3, tn, mo);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
